// File: rtl/heap_pkg.sv
// Shared types for the heap front-end: op codes, status codes, FSM states.
// Also provides a small index-width helper used by the arbiter and top.
package heap_pkg;

   localparam logic OP_PUSH = 1'b0;
   localparam logic OP_POP  = 1'b1;

   typedef enum logic [1:0] {
      ERR_OK      = 2'd0,
      ERR_FULL    = 2'd1,
      ERR_EMPTY   = 2'd2,
      ERR_TIMEOUT = 2'd3
   } heap_err_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } heap_arb_state_e;

   // Index width that never collapses to zero bits.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Ports: req (NREQ), ptr (start index) -> gnt (one-hot), idx (encoded).
module rr_arbiter
   import heap_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx
);

   logic found;
   int   pos;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < NREQ; k++) begin
         pos = (int'(ptr) + k) % NREQ;
         if (!found && req[pos]) begin
            found    = 1'b1;
            gnt[pos] = 1'b1;
            idx      = IW'(pos);
         end
      end
   end

endmodule

// File: rtl/heap_arbiter.sv
// Shares one heap engine among NREQ requesters: round-robin grant,
// full/empty precheck, start/done handshake, watchdog, one-hot response.
// Ports: clk, reset_n; req_valid/op/key -> req_ready; rsp_valid/key/err;
//        eng_start/op/key -> engine; eng_done/top/n <- engine.
module heap_arbiter
   import heap_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int KEY_W   = 32,
   parameter int DEPTH   = 1024,
   parameter int CNT_W   = 11,
   parameter int TIMEOUT = 4096
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ-1:0]         req_op,
   input  logic [NREQ*KEY_W-1:0]   req_key,
   output logic [NREQ-1:0]         req_ready,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [KEY_W-1:0]        rsp_key,
   output logic [1:0]              rsp_err,
   output logic                    eng_start,
   output logic                    eng_op,
   output logic [KEY_W-1:0]        eng_key,
   input  logic                    eng_done,
   input  logic [KEY_W-1:0]        eng_top,
   input  logic [CNT_W-1:0]        eng_n
);

   localparam int IW   = idx_w(NREQ);
   localparam int WD_W = idx_w(TIMEOUT);
   localparam logic [WD_W-1:0] WD_LAST =
      WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   heap_arb_state_e state_q, state_d;

   logic [IW-1:0]    ptr_q, ptr_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic             op_q, op_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic [WD_W-1:0]  wd_q, wd_d;
   logic [NREQ-1:0]  rvld_q, rvld_d;
   logic [KEY_W-1:0] rkey_q, rkey_d;
   heap_err_e        rerr_q, rerr_d;
   logic             rsp_go;

   logic [NREQ-1:0]  win_gnt;
   logic [IW-1:0]    win_idx;
   logic             win_op;
   logic [KEY_W-1:0] win_key;
   logic             full, empty;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (win_gnt),
      .idx (win_idx)
   );

   assign win_op  = req_op[win_idx];
   assign win_key = req_key[win_idx*KEY_W +: KEY_W];
   assign full    = (eng_n == CNT_W'(DEPTH));
   assign empty   = (eng_n == '0);

   // Grant is Mealy; held off while reset is asserted so outputs read 0.
   assign req_ready = (state_q == ST_IDLE && reset_n) ? win_gnt : '0;

   assign eng_start = (state_q == ST_ISSUE);
   assign eng_op    = op_q;
   assign eng_key   = key_q;
   assign rsp_valid = rvld_q;
   assign rsp_key   = rkey_q;
   assign rsp_err   = rerr_q;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      op_d    = op_q;
      key_d   = key_q;
      wd_d    = wd_q;
      rvld_d  = '0;
      rkey_d  = '0;
      rerr_d  = ERR_OK;
      rsp_go  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               idx_d = win_idx;
               op_d  = win_op;
               key_d = win_key;
               ptr_d = (win_idx == IW'(NREQ - 1)) ? '0
                                                  : win_idx + 1'b1;
               if (win_op == OP_PUSH && full) begin
                  rsp_go = 1'b1;
                  rerr_d = ERR_FULL;
               end else if (win_op == OP_POP && empty) begin
                  rsp_go = 1'b1;
                  rerr_d = ERR_EMPTY;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            wd_d    = '0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (eng_done) begin
               rsp_go = 1'b1;
               rerr_d = ERR_OK;
               if (op_q == OP_POP) rkey_d = eng_top;
            end else if (TIMEOUT != 0) begin
               wd_d = wd_q + 1'b1;
               if (wd_q == WD_LAST) begin
                  rsp_go = 1'b1;
                  rerr_d = ERR_TIMEOUT;
               end
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Response registers load on entry to RESP, so they line up with it.
      if (rsp_go) begin
         state_d       = ST_RESP;
         rvld_d[idx_d] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         op_q    <= 1'b0;
         key_q   <= '0;
         wd_q    <= '0;
         rvld_q  <= '0;
         rkey_q  <= '0;
         rerr_q  <= ERR_OK;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         op_q    <= op_d;
         key_q   <= key_d;
         wd_q    <= wd_d;
         rvld_q  <= rvld_d;
         rkey_q  <= rkey_d;
         rerr_q  <= rerr_d;
      end
   end

endmodule

// File: tb/tb_heap_arbiter.sv
// Randomized bench for heap_arbiter with a transaction-level reference.
// The bench plays the engine and predicts grant, status and timing.
module tb_heap_arbiter;
   import heap_pkg::*;

   localparam int NREQ    = 4;
   localparam int KEY_W   = 32;
   localparam int DEPTH   = 1024;
   localparam int CNT_W   = 11;
   localparam int TIMEOUT = 8;

   logic                  clk = 1'b0;
   logic                  reset_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_op;
   logic [NREQ*KEY_W-1:0] req_key;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ-1:0]       rsp_valid;
   logic [KEY_W-1:0]      rsp_key;
   logic [1:0]            rsp_err;
   logic                  eng_start;
   logic                  eng_op;
   logic [KEY_W-1:0]      eng_key;
   logic                  eng_done;
   logic [KEY_W-1:0]      eng_top;
   logic [CNT_W-1:0]      eng_n;

   int n_chk = 0;
   int n_err = 0;
   int ptr   = 0;

   heap_arbiter #(
      .NREQ    (NREQ),
      .KEY_W   (KEY_W),
      .DEPTH   (DEPTH),
      .CNT_W   (CNT_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_op    (req_op),
      .req_key   (req_key),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_key   (rsp_key),
      .rsp_err   (rsp_err),
      .eng_start (eng_start),
      .eng_op    (eng_op),
      .eng_key   (eng_key),
      .eng_done  (eng_done),
      .eng_top   (eng_top),
      .eng_n     (eng_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Fair rotation: first pending requester at or after the pointer.
   function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++)
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   // lat < 0: engine never answers (watchdog path).
   task automatic xact(input logic [NREQ-1:0] pat,
                       input logic [NREQ-1:0] ops,
                       input logic [NREQ*KEY_W-1:0] keys,
                       input logic [CNT_W-1:0] n,
                       input int lat,
                       input logic [KEY_W-1:0] top);
      int w;
      int exp_err;
      logic [NREQ-1:0] oh;
      logic op;
      logic [KEY_W-1:0] k;
      logic [KEY_W-1:0] exp_key;
      @(negedge clk);
      req_valid = pat;
      req_op    = ops;
      req_key   = keys;
      eng_n     = n;
      #1;
      w = rr_pick(pat, ptr);
      oh = '0;
      oh[w] = 1'b1;
      check("grant", 64'(req_ready), 64'(oh));
      check("idle_rsp", 64'(rsp_valid), 64'(0));
      ptr = (w + 1) % NREQ;
      op = ops[w];
      k = keys[w*KEY_W +: KEY_W];
      if (op == 1'b0 && int'(n) == DEPTH) exp_err = 1;
      else if (op == 1'b1 && n == 0) exp_err = 2;
      else exp_err = 0;
      @(negedge clk);
      if (exp_err != 0) begin
         check("rej_start", 64'(eng_start), 64'(0));
         check("rej_vld", 64'(rsp_valid), 64'(oh));
         check("rej_err", 64'(rsp_err), 64'(exp_err));
         check("rej_key", 64'(rsp_key), 64'(0));
         return;
      end
      check("start", 64'(eng_start), 64'(1));
      check("eng_op", 64'(eng_op), 64'(op));
      check("eng_key", 64'(eng_key), 64'(k));
      check("busy_ready", 64'(req_ready), 64'(0));
      if (lat >= 0) begin
         repeat (lat) @(negedge clk);
         @(negedge clk);
         check("wait_start", 64'(eng_start), 64'(0));
         check("wait_vld", 64'(rsp_valid), 64'(0));
         eng_done = 1'b1;
         eng_top  = top;
         @(negedge clk);
         eng_done = 1'b0;
         exp_key = op ? top : '0;
         check("rsp_vld", 64'(rsp_valid), 64'(oh));
         check("rsp_err", 64'(rsp_err), 64'(0));
         check("rsp_key", 64'(rsp_key), 64'(exp_key));
      end else begin
         repeat (TIMEOUT) @(negedge clk);
         check("wd_early", 64'(rsp_valid), 64'(0));
         @(negedge clk);
         check("wd_vld", 64'(rsp_valid), 64'(oh));
         check("wd_err", 64'(rsp_err), 64'(3));
         check("wd_key", 64'(rsp_key), 64'(0));
         req_valid = '0;
         @(negedge clk);
         eng_done = 1'b1;
         eng_top  = top;
         @(negedge clk);
         eng_done = 1'b0;
         check("stray_vld", 64'(rsp_valid), 64'(0));
         check("stray_start", 64'(eng_start), 64'(0));
      end
   endtask

   function automatic logic [NREQ*KEY_W-1:0] rnd_keys();
      logic [NREQ*KEY_W-1:0] r;
      for (int i = 0; i < NREQ; i++) r[i*KEY_W +: KEY_W] = $urandom;
      return r;
   endfunction

   initial begin
      logic [NREQ*KEY_W-1:0] keys;
      logic [NREQ-1:0] pat;
      logic [NREQ-1:0] ops;
      logic [CNT_W-1:0] n;
      int lat;
      int sel;

      reset_n   = 1'b0;
      req_valid = '1;
      req_op    = '0;
      req_key   = '0;
      eng_done  = 1'b0;
      eng_top   = '0;
      eng_n     = '0;
      #12;
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_vld", 64'(rsp_valid), 64'(0));
      check("rst_start", 64'(eng_start), 64'(0));
      check("rst_eop", 64'(eng_op), 64'(0));
      check("rst_ekey", 64'(eng_key), 64'(0));
      check("rst_rkey", 64'(rsp_key), 64'(0));
      check("rst_err", 64'(rsp_err), 64'(0));
      @(negedge clk);
      req_valid = '0;
      reset_n   = 1'b1;

      // All requesters pending every cycle: rotation 0,1,2,3,0.
      for (int i = 0; i < 5; i++)
         xact('1, '0, rnd_keys(), CNT_W'(100), 1, '0);

      keys = '0;
      keys[0 +: KEY_W] = 32'd15;
      xact(4'b0001, 4'b0000, keys, CNT_W'(10), 4, '0);
      xact(4'b0010, 4'b0010, rnd_keys(), CNT_W'(0), 0, '0);
      xact(4'b0100, 4'b0000, rnd_keys(), CNT_W'(DEPTH), 0, '0);
      xact(4'b1000, 4'b1000, rnd_keys(), CNT_W'(3), 2, 32'd20);
      xact(4'b0001, 4'b0000, rnd_keys(), CNT_W'(3), -1, 32'd7);

      for (int t = 0; t < 80; t++) begin
         pat = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         ops = NREQ'($urandom);
         sel = $urandom_range(0, 7);
         if (sel == 0) n = '0;
         else if (sel == 1) n = CNT_W'(DEPTH);
         else n = CNT_W'($urandom_range(1, DEPTH - 1));
         lat = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(0, 5);
         xact(pat, ops, rnd_keys(), n, lat, KEY_W'($urandom));
      end

      // Abort in WAIT with an asynchronous reset.
      @(negedge clk);
      req_valid = '1;
      req_op    = '1;
      req_key   = {NREQ{32'hA5A5_0001}};
      eng_n     = CNT_W'(5);
      @(negedge clk);
      req_valid = '1;
      @(negedge clk);
      @(negedge clk);
      check("pre_rst_op", 64'(eng_op), 64'(1));
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_ready", 64'(req_ready), 64'(0));
      check("arst_vld", 64'(rsp_valid), 64'(0));
      check("arst_start", 64'(eng_start), 64'(0));
      check("arst_eop", 64'(eng_op), 64'(0));
      check("arst_ekey", 64'(eng_key), 64'(0));
      check("arst_rkey", 64'(rsp_key), 64'(0));
      check("arst_err", 64'(rsp_err), 64'(0));
      @(negedge clk);
      req_valid = '0;
      reset_n   = 1'b1;
      ptr       = 0;
      xact('1, '0, rnd_keys(), CNT_W'(5), 0, '0);

      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
